fetch_queue: RTL and testbench

Instruction prefetch queue between a request/grant instruction memory port and the IF/ID pipeline register of the RISC-V-lite core. It generates sequential word fetch addresses, keeps up to DEPTH fetches in flight or buffered, and presents instructions with their PC to the decode side over a valid/ready handshake. A redirect input from the branch/jump resolution logic (pc_src / jmp_addr) flushes the queue, discards in-flight responses and restarts fetching at the target.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_queue.sv | 85 ++++++++
 tb/tb_fetch_queue.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

   localparam int INST_W = 32;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory fetch port, redirect and decode-side handshake of the prefetch queue.
interface fetch_queue_if;
   import fetch_pkg::*;

   logic              flush_i;
   logic [XLEN-1:0]   flush_addr_i;
   logic              mem_req_o;
   logic [XLEN-1:0]   mem_addr_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [INST_W-1:0] mem_rdata_i;
   logic              inst_valid_o;
   logic [INST_W-1:0] inst_o;
   logic [XLEN-1:0]   inst_addr_o;
   logic              inst_ready_i;

   modport master (
      input  flush_i, flush_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i,
      output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o
   );

   modport slave (
      output flush_i, flush_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i,
      input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o
   );

endinterface

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO of fetched {pc, instruction} entries.
module fetch_fifo import fetch_pkg::*; #(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         push_i,
   input  fetch_entry_t pushData_i,
   input  logic         pop_i,
   output logic         headValid_o,
   output fetch_entry_t headData_o,
   output logic [CW-1:0] count_o
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  storage_q [DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          doPop;

   assign doPop = pop_i && (count_q != '0);

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push_i) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop) rdPtr_d = rdPtr_q + 1'b1;
      if (push_i && !doPop) count_d = count_q + 1'b1;
      else if (!push_i && doPop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push_i) storage_q[wrPtr_q] <= pushData_i;
   end

   assign headValid_o = (count_q != '0);
   assign headData_o  = headValid_o ? storage_q[rdPtr_q] : '0;
   assign count_o     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch issue, response tracking and redirect flush.
module fetch_queue import fetch_pkg::*; #(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   fetch_queue_if.master bus
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] fetchPc_q, fetchPc_d;
   logic [XLEN-1:0] respPc_q, respPc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   occupancy;
   logic [CW:0]     creditSum;
   logic            memReq, grant, respValid, respKeep, popReq, headValid;
   fetch_entry_t    headData, pushData;

   // Buffered plus in-flight fetches never exceed DEPTH, so a push always finds room.
   assign creditSum = {1'b0, occupancy} + {1'b0, outstanding_q};
   assign memReq    = !rst_i && (creditSum < (CW+1)'(DEPTH));
   assign grant     = memReq && bus.mem_gnt_i;
   assign respValid = bus.mem_rvalid_i && (outstanding_q != '0);
   assign respKeep  = respValid && (discard_q == '0) && !bus.flush_i;
   assign popReq    = bus.inst_ready_i && headValid && !bus.flush_i;

   assign pushData.addr = respPc_q;
   assign pushData.inst = bus.mem_rdata_i;

   always_comb begin
      outstanding_d = outstanding_q + CW'(grant) - CW'(respValid);
      discard_d     = discard_q;
      fetchPc_d     = fetchPc_q;
      respPc_d      = respPc_q;
      if (bus.flush_i) begin
         discard_d = outstanding_d;
         fetchPc_d = alignWord(bus.flush_addr_i);
         respPc_d  = alignWord(bus.flush_addr_i);
      end else begin
         if (respValid && (discard_q != '0)) discard_d = discard_q - 1'b1;
         if (grant) fetchPc_d = fetchPc_q + PC_STEP;
         if (respKeep) respPc_d = respPc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetchPc_q     <= alignWord(RESET_PC);
         respPc_q      <= alignWord(RESET_PC);
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetchPc_q     <= fetchPc_d;
         respPc_q      <= respPc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (bus.flush_i),
      .push_i     (respKeep),
      .pushData_i (pushData),
      .pop_i      (popReq),
      .headValid_o(headValid),
      .headData_o (headData),
      .count_o    (occupancy)
   );

   assign bus.mem_req_o    = memReq;
   assign bus.mem_addr_o   = fetchPc_q;
   assign bus.inst_valid_o = headValid;
   assign bus.inst_o       = headData.inst;
   assign bus.inst_addr_o  = headData.addr;

   // A response with nothing outstanding is a memory protocol violation and is ignored.
   rvalidNeedsOutstanding: assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus.mem_rvalid_i && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench: in-order memory model with random latency and a PC-stream scoreboard.
module tb_fetch_queue;

   typedef struct {
      logic [31:0] addr;
      int          readyCycle;
   } pendEntry_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_queue_if fq ();
   fetch_queue_if fq2 ();

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (fq.master)
   );

   fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dutWrap (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (fq2.master)
   );

   always #5 clk = ~clk;

   int          testsRun = 0;
   int          testsFailed = 0;
   int          cycle = 0;
   int          sinceReset = 0;
   int          grantCount = 0;
   int          popCount = 0;
   bit          rstMode = 1'b1;
   bit          hold = 1'b0;
   int          gntMode = 0;
   int          readyMode = 0;
   int          latMax = 0;
   logic        obsReq, obsValid, lastGnt, lastRvalid;
   logic [31:0] obsAddr, obsInst, obsInstAddr;
   pendEntry_t  pending [$];
   logic [31:0] expQ [$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, observed, expected, cycle);
      end
   endtask

   // One clock cycle: sample outputs, drive memory/consumer/redirect, update the models.
   task automatic applyStimulus(input bit doFlush, input logic [31:0] target);
      logic        gnt, rvalid, ready;
      logic [31:0] rdata, e;
      pendEntry_t  pe;
      @(negedge clk);
      rst = rstMode;
      #1;
      obsReq      = fq.mem_req_o;
      obsAddr     = fq.mem_addr_o;
      obsValid    = fq.inst_valid_o;
      obsInst     = fq.inst_o;
      obsInstAddr = fq.inst_addr_o;
      if (rstMode) begin
         pending.delete();
         expQ.delete();
         expQ.push_back(32'h0000_0000);
         sinceReset = 0;
         fq.mem_gnt_i    = 1'b0;
         fq.mem_rvalid_i = 1'b0;
         fq.mem_rdata_i  = 32'hDEAD_BEEF;
         fq.inst_ready_i = 1'b0;
         fq.flush_i      = 1'b0;
         fq.flush_addr_i = 32'h0;
         lastGnt = 1'b0;
         lastRvalid = 1'b0;
      end else begin
         if (sinceReset < 3)
            checkOutput("wrap_addr", fq2.mem_addr_o, 32'hFFFF_FFF8 + 32'(4 * sinceReset));
         case (gntMode)
            0: gnt = 1'b1;
            1: gnt = 1'($urandom_range(0, 1));
            default: gnt = 1'b0;
         endcase
         rvalid = !hold && (pending.size() > 0) && (pending[0].readyCycle <= cycle);
         rdata  = rvalid ? pending[0].addr : 32'hDEAD_BEEF;
         case (readyMode)
            0: ready = 1'b0;
            1: ready = 1'b1;
            default: ready = 1'($urandom_range(0, 1));
         endcase
         fq.mem_gnt_i    = gnt;
         fq.mem_rvalid_i = rvalid;
         fq.mem_rdata_i  = rdata;
         fq.inst_ready_i = ready;
         fq.flush_i      = doFlush;
         fq.flush_addr_i = target;
         lastGnt = gnt;
         lastRvalid = rvalid;
         if (rvalid) void'(pending.pop_front());
         if (obsReq && gnt) begin
            pe.addr = obsAddr;
            pe.readyCycle = cycle + 1 + $urandom_range(0, latMax);
            pending.push_back(pe);
            grantCount++;
         end
         if (obsValid && ready && !doFlush && (expQ.size() > 0)) begin
            e = expQ.pop_front();
            checkOutput("pop_addr", obsInstAddr, e);
            checkOutput("pop_inst", obsInst, e);
            expQ.push_back(e + 32'd4);
            popCount++;
         end
         if (doFlush) begin
            expQ.delete();
            expQ.push_back({target[31:2], 2'b00});
         end
         sinceReset++;
      end
      cycle++;
   endtask

   task automatic resetDut(input int cycles);
      rstMode = 1'b1;
      repeat (cycles) applyStimulus(1'b0, 32'h0);
      rstMode = 1'b0;
   endtask

   initial begin
      fq2.flush_i      = 1'b0;
      fq2.flush_addr_i = 32'h0;
      fq2.mem_gnt_i    = 1'b1;
      fq2.mem_rvalid_i = 1'b0;
      fq2.mem_rdata_i  = 32'h0;
      fq2.inst_ready_i = 1'b0;
      fq.flush_i       = 1'b0;
      fq.flush_addr_i  = 32'h0;
      fq.mem_gnt_i     = 1'b0;
      fq.mem_rvalid_i  = 1'b0;
      fq.mem_rdata_i   = 32'h0;
      fq.inst_ready_i  = 1'b0;

      // Reset values, then a zero-wait stream at one instruction per cycle.
      resetDut(3);
      checkOutput("rst_req", 32'(obsReq), 32'd0);
      checkOutput("rst_valid", 32'(obsValid), 32'd0);
      checkOutput("rst_inst", obsInst, 32'h0);
      checkOutput("rst_inst_addr", obsInstAddr, 32'h0);
      gntMode = 0; latMax = 0; readyMode = 1; hold = 1'b0;
      applyStimulus(1'b0, 32'h0);
      checkOutput("first_req", 32'(obsReq), 32'd1);
      checkOutput("first_addr", obsAddr, 32'h0);
      applyStimulus(1'b0, 32'h0);
      popCount = 0;
      repeat (16) applyStimulus(1'b0, 32'h0);
      checkOutput("throughput", 32'(popCount), 32'd16);

      // Redirect coinciding with grant, response and pop.
      applyStimulus(1'b1, 32'h0000_0200);
      checkOutput("coinc_req", 32'(obsReq && lastGnt), 32'd1);
      checkOutput("coinc_rvalid", 32'(lastRvalid), 32'd1);
      checkOutput("coinc_valid", 32'(obsValid), 32'd1);
      applyStimulus(1'b0, 32'h0);
      checkOutput("coinc_next_valid", 32'(obsValid), 32'd0);
      checkOutput("coinc_next_addr", obsAddr, 32'h0000_0200);
      repeat (10) applyStimulus(1'b0, 32'h0);

      // Consumer stalled: exactly DEPTH grants, head held at 0x0.
      resetDut(2);
      readyMode = 0;
      grantCount = 0;
      repeat (10) applyStimulus(1'b0, 32'h0);
      checkOutput("stall_grants", 32'(grantCount), 32'd4);
      checkOutput("stall_valid", 32'(obsValid), 32'd1);
      checkOutput("stall_inst_addr", obsInstAddr, 32'h0);
      checkOutput("stall_inst", obsInst, 32'h0);
      checkOutput("stall_req", 32'(obsReq), 32'd0);
      readyMode = 1;
      repeat (12) applyStimulus(1'b0, 32'h0);

      // Flush with three fetches in flight; stale responses must be dropped.
      resetDut(2);
      readyMode = 1; gntMode = 0; hold = 1'b1;
      repeat (3) applyStimulus(1'b0, 32'h0);
      gntMode = 2;
      applyStimulus(1'b1, 32'h0000_0103);
      gntMode = 0; hold = 1'b0;
      applyStimulus(1'b0, 32'h0);
      checkOutput("flush_addr", obsAddr, 32'h0000_0100);
      checkOutput("flush_valid", 32'(obsValid), 32'd0);
      checkOutput("flush_req", 32'(obsReq), 32'd1);
      popCount = 0;
      repeat (12) applyStimulus(1'b0, 32'h0);
      checkOutput("flush_pops", 32'(popCount), 32'd9);

      // Reset in the middle of a running stream.
      rstMode = 1'b1;
      applyStimulus(1'b0, 32'h0);
      checkOutput("midrst_req", 32'(obsReq), 32'd0);
      rstMode = 1'b0;
      applyStimulus(1'b0, 32'h0);
      checkOutput("midrst_valid", 32'(obsValid), 32'd0);
      checkOutput("midrst_addr", obsAddr, 32'h0);
      checkOutput("midrst_req_after", 32'(obsReq), 32'd1);
      repeat (10) applyStimulus(1'b0, 32'h0);

      // Random grant/response latency, consumer stalls and redirects.
      gntMode = 1; latMax = 4; readyMode = 2;
      popCount = 0;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 31) == 0), $urandom);
         checkOutput("outstanding_bound", (pending.size() <= 4) ? 32'd1 : 32'd0, 32'd1);
      end
      checkOutput("random_pops", (popCount > 100) ? 32'd1 : 32'd0, 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
